// File: rtl/read_16x8_array_div.sv
// -----------------------------------------------------------------------------
// read_16x8_array_div
//
// Approximate-capable 16-by-8 restoring array divider. Eight subtractor rows of
// nine full-subtractor cells each. Per-row masks pick, cell by cell, an exact
// or an approximate cell for cells 0..7; cell 8 of every row is always exact.
// The array is purely combinational; its result is registered once.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous, active-high reset
//   in_valid   in   1   operands valid this cycle
//   x          in  16   dividend
//   y          in   8   divisor
//   bin        in   1   borrow-in to cell 0 of every row (normally 0)
//   app1..app8 in   8   row masks, app1 = first row (q[7]), app8 = last row (q[0]);
//                       bit j = 1 makes cell j exact, 0 makes it approximate
//   q          out  8   quotient, registered
//   r          out  8   remainder, registered
//   out_valid  out  1   q/r valid (one cycle after in_valid)
//
// Optional build macro READ_DIV_STATUS_EN adds registered status outputs:
//   div_zero   out  1   captured operation had y == 0
//   ovf        out  1   captured operation had y != 0 and x[15:8] >= y
// -----------------------------------------------------------------------------
module read_16x8_array_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] x,
    input  logic [7:0]  y,
    input  logic        bin,
    input  logic [7:0]  app1,
    input  logic [7:0]  app2,
    input  logic [7:0]  app3,
    input  logic [7:0]  app4,
    input  logic [7:0]  app5,
    input  logic [7:0]  app6,
    input  logic [7:0]  app7,
    input  logic [7:0]  app8,
    output logic [7:0]  q,
    output logic [7:0]  r,
    output logic        out_valid
`ifdef READ_DIV_STATUS_EN
    ,
    output logic        div_zero,
    output logic        ovf
`endif
);

    // Exact cell:  D = a^b^bi, Bout = ~a&b | ~a&bi | b&bi
    // Approx cell: D = a^b,    Bout = ~a&b | ~a&bi
    function automatic logic cell_diff(input logic a, input logic b, input logic bi,
                                       input logic exact);
        return exact ? (a ^ b ^ bi) : (a ^ b);
    endfunction

    function automatic logic cell_borrow(input logic a, input logic b, input logic bi,
                                         input logic exact);
        return (~a & b) | (~a & bi) | (exact & b & bi);
    endfunction

    // app_rows[0] is the first row (app1), app_rows[7] the last (app8).
    logic [7:0][7:0] app_rows;
    assign app_rows = {app8, app7, app6, app5, app4, app3, app2, app1};

    // ------------------------------------------------------------------
    // Combinational array
    // ------------------------------------------------------------------
    logic [7:0] arr_quo;
    logic [7:0] arr_rem;
    logic [7:0] p_row;
    logic [8:0] a_row;
    logic [8:0] d_row;
    logic       brw;

    always_comb begin
        arr_quo = '0;
        arr_rem = '0;
        a_row   = '0;
        d_row   = '0;
        brw     = 1'b0;
        p_row   = x[15:8];
        for (int i = 0; i < 8; i++) begin
            // Row i+1 brings down dividend bit x[7-i].
            a_row = {p_row, x[7-i]};
            brw   = bin;
            for (int j = 0; j < 8; j++) begin
                d_row[j] = cell_diff(a_row[j], y[j], brw, app_rows[i][j]);
                brw      = cell_borrow(a_row[j], y[j], brw, app_rows[i][j]);
            end
            // Cell 8 is always exact and its subtrahend bit is 0.
            d_row[8] = a_row[8] ^ brw;
            brw      = ~a_row[8] & brw;
            // A final borrow means A < y: quotient bit 0 and restore the minuend.
            arr_quo[7-i] = ~brw;
            p_row        = brw ? a_row[7:0] : d_row[7:0];
        end
        arr_rem = p_row;
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic [7:0] q_d, q_q;
    logic [7:0] r_d, r_q;
    logic       out_valid_d, out_valid_q;

    always_comb begin
        q_d         = q_q;
        r_d         = r_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            out_valid_d = 1'b1;
            if (y == 8'd0) begin
                // Divide by zero bypasses the array.
                q_d = 8'hFF;
                r_d = x[7:0];
            end else begin
                q_d = arr_quo;
                r_d = arr_rem;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q         <= 8'd0;
            r_q         <= 8'd0;
            out_valid_q <= 1'b0;
        end else begin
            q_q         <= q_d;
            r_q         <= r_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign q         = q_q;
    assign r         = r_q;
    assign out_valid = out_valid_q;

`ifdef READ_DIV_STATUS_EN
    logic div_zero_d, div_zero_q;
    logic ovf_d, ovf_q;

    always_comb begin
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        if (in_valid) begin
            div_zero_d = (y == 8'd0);
            ovf_d      = (y != 8'd0) && (x[15:8] >= y);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end

    assign div_zero = div_zero_q;
    assign ovf      = ovf_q;
`endif

endmodule

// File: tb/tb_read_16x8_array_div.sv
// -----------------------------------------------------------------------------
// Testbench for read_16x8_array_div. Stimulus pushes expected results into a
// queue; an independent monitor pops and compares whenever the DUT captured.
// -----------------------------------------------------------------------------
module tb_read_16x8_array_div;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] x;
    logic [7:0]  y;
    logic        bin;
    logic [63:0] masks;   // masks[8*k +: 8] drives row k+1
    logic [7:0]  q;
    logic [7:0]  r;
    logic        out_valid;
`ifdef READ_DIV_STATUS_EN
    logic        div_zero;
    logic        ovf;
`endif

    read_16x8_array_div dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .bin       (bin),
        .app1      (masks[7:0]),
        .app2      (masks[15:8]),
        .app3      (masks[23:16]),
        .app4      (masks[31:24]),
        .app5      (masks[39:32]),
        .app6      (masks[47:40]),
        .app7      (masks[55:48]),
        .app8      (masks[63:56]),
        .q         (q),
        .r         (r),
        .out_valid (out_valid)
`ifdef READ_DIV_STATUS_EN
        ,
        .div_zero  (div_zero),
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference divider. Rows whose mask is all-exact are a plain 9-bit
    // subtraction A - y - bin; other rows follow the cell truth tables bit by bit.
    function automatic logic [15:0] ref_div(input logic [15:0] xv, input logic [7:0] yv,
                                            input logic bv, input logic [63:0] mv);
        logic [7:0] p;
        logic [7:0] quo;
        logic [8:0] a;
        logic [8:0] d;
        logic [8:0] ye;
        logic       bw;
        logic       ex;
        logic [7:0] m;
        int         diff;
        if (yv == 8'd0) return {8'hFF, xv[7:0]};
        p   = xv[15:8];
        quo = '0;
        ye  = {1'b0, yv};
        for (int i = 1; i <= 8; i++) begin
            a = {p, xv[8-i]};
            m = mv[8*(i-1) +: 8];
            if (m == 8'hFF) begin
                diff = int'(a) - int'(yv) - int'(bv);
                bw   = (diff < 0);
                d    = diff[8:0];
            end else begin
                bw = bv;
                for (int j = 0; j < 9; j++) begin
                    ex   = (j == 8) ? 1'b1 : m[j];
                    d[j] = ex ? (a[j] ^ ye[j] ^ bw) : (a[j] ^ ye[j]);
                    bw   = (~a[j] & ye[j]) | (~a[j] & bw) | (ex & ye[j] & bw);
                end
            end
            quo[8-i] = ~bw;
            p        = bw ? a[7:0] : d[7:0];
        end
        return {quo, p};
    endfunction

    function automatic exp_t mk_exp(input logic [15:0] xv, input logic [7:0] yv,
                                    input logic [7:0] eq, input logic [7:0] er);
        exp_t e;
        e.q   = eq;
        e.r   = er;
        e.dz  = (yv == 8'd0);
        e.ovf = (yv != 8'd0) && (xv[15:8] >= yv);
        return e;
    endfunction

    // Issue one operation with an explicitly known expected result.
    task automatic issue_const(input logic [15:0] xv, input logic [7:0] yv, input logic bv,
                               input logic [63:0] mv, input logic [7:0] eq,
                               input logic [7:0] er);
        @(negedge clk);
        x        = xv;
        y        = yv;
        bin      = bv;
        masks    = mv;
        in_valid = 1'b1;
        exp_q.push_back(mk_exp(xv, yv, eq, er));
    endtask

    task automatic issue_model(input logic [15:0] xv, input logic [7:0] yv, input logic bv,
                               input logic [63:0] mv);
        logic [15:0] res;
        res = ref_div(xv, yv, bv, mv);
        issue_const(xv, yv, bv, mv, res[15:8], res[7:0]);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        x        = 16'($urandom);
        y        = 8'($urandom);
        bin      = 1'($urandom);
        masks    = {$urandom, $urandom};
    endtask

    // Monitor: decides from the inputs seen at each edge what the DUT must show.
    initial begin : monitor
        logic cap;
        logic rs;
        logic [7:0] hold_q;
        logic [7:0] hold_r;
        exp_t e;
        hold_q = 8'd0;
        hold_r = 8'd0;
        forever begin
            @(posedge clk);
            cap = in_valid && !rst;
            rs  = rst;
            #1;
            if (rs) begin
                chk("reset_out_valid", 32'(out_valid), 32'd0);
                chk("reset_q", 32'(q), 32'd0);
                chk("reset_r", 32'(r), 32'd0);
`ifdef READ_DIV_STATUS_EN
                chk("reset_div_zero", 32'(div_zero), 32'd0);
                chk("reset_ovf", 32'(ovf), 32'd0);
`endif
                hold_q = 8'd0;
                hold_r = 8'd0;
            end else if (cap) begin
                chk("capture_out_valid", 32'(out_valid), 32'd1);
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("quotient", 32'(q), 32'(e.q));
                    chk("remainder", 32'(r), 32'(e.r));
`ifdef READ_DIV_STATUS_EN
                    chk("div_zero", 32'(div_zero), 32'(e.dz));
                    chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
                    hold_q = e.q;
                    hold_r = e.r;
                end
            end else begin
                chk("idle_out_valid", 32'(out_valid), 32'd0);
                chk("hold_q", 32'(q), 32'(hold_q));
                chk("hold_r", 32'(r), 32'(hold_r));
            end
        end
    end

    localparam logic [63:0] ExactMasks = {8{8'hFF}};
    localparam logic [63:0] ApproxLast = {8'h00, {7{8'hFF}}};

    initial begin : stim
        logic [15:0] xv;
        logic [7:0]  yv;
        logic        bv;
        logic [63:0] mv;

        // Reset held for two edges while in_valid is high.
        rst      = 1'b1;
        in_valid = 1'b1;
        x        = 16'h1234;
        y        = 8'd3;
        bin      = 1'b0;
        masks    = ExactMasks;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;

        // Exact division, back to back.
        issue_const(16'd8,   8'd4,  1'b0, ExactMasks, 8'd2,  8'd0);
        issue_const(16'd7,   8'd3,  1'b0, ExactMasks, 8'd2,  8'd1);
        issue_const(16'd16,  8'd4,  1'b0, ExactMasks, 8'd4,  8'd0);
        issue_const(16'd40,  8'd13, 1'b0, ExactMasks, 8'd3,  8'd1);
        issue_const(16'd199, 8'd7,  1'b0, ExactMasks, 8'd28, 8'd3);
        issue_const(16'd127, 8'd5,  1'b0, ExactMasks, 8'd25, 8'd2);
        idle();

        // Approximate last row.
        issue_const(16'd40, 8'd13, 1'b0, ApproxLast, 8'd3, 8'd3);
        issue_const(16'd7,  8'd3,  1'b0, ApproxLast, 8'd2, 8'd1);
        idle();
        idle();

        // Divide by zero and overflow.
        issue_const(16'h1234, 8'd0, 1'b0, ExactMasks, 8'hFF, 8'h34);
        issue_const(16'h0500, 8'd5, 1'b0, ExactMasks, 8'hFF, 8'h05);
        issue_model(16'hFF00, 8'd1, 1'b0, ExactMasks);
        idle();

        // Randomized operations with random idle gaps.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                case ($urandom_range(0, 9))
                    0:       yv = 8'd0;
                    1, 2:    yv = 8'($urandom_range(1, 15));
                    default: yv = 8'($urandom);
                endcase
                xv = 16'($urandom);
                if (yv != 8'd0 && $urandom_range(0, 3) != 0) begin
                    xv[15:8] = 8'($urandom_range(0, int'(yv) - 1));
                end
                bv = ($urandom_range(0, 9) == 0);
                for (int k = 0; k < 8; k++) begin
                    mv[8*k +: 8] = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
                end
                issue_model(xv, yv, bv, mv);
            end
        end

        repeat (3) idle();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
